// File: rtl/draw_scheduler.sv
// draw_scheduler: round-robin owner of the single VGA plot port. Latches one
// requester's rectangle, sweeps it row-major one pixel per cycle (clipping
// off-screen pixels), then pulses done to that owner.
module draw_scheduler #(
  parameter int unsigned N_REQ    = 2,
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned SZ_W     = 5,
  parameter int unsigned COL_W    = 3,
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*X_W-1:0]   x_in,
  input  logic [N_REQ*Y_W-1:0]   y_in,
  input  logic [N_REQ*SZ_W-1:0]  w_in,
  input  logic [N_REQ*SZ_W-1:0]  h_in,
  input  logic [N_REQ*COL_W-1:0] colour_in,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [X_W-1:0]         vga_x,
  output logic [Y_W-1:0]         vga_y,
  output logic [COL_W-1:0]       vga_colour,
  output logic                   vga_plot
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned REC_W = PTR_W + X_W + Y_W + 2 * SZ_W + COL_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [X_W-1:0]     bx_q, bx_d;
  logic [Y_W-1:0]     by_q, by_d;
  logic [SZ_W-1:0]    bw_q, bw_d;
  logic [SZ_W-1:0]    bh_q, bh_d;
  logic [COL_W-1:0]   bc_q, bc_d;
  logic [SZ_W-1:0]    col_q, col_d;
  logic [SZ_W-1:0]    row_q, row_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               busy_q, busy_d;
  logic [X_W-1:0]     vga_x_q, vga_x_d;
  logic [Y_W-1:0]     vga_y_q, vga_y_d;
  logic [COL_W-1:0]   vga_colour_q, vga_colour_d;
  logic               vga_plot_q, vga_plot_d;

  logic [N_REQ-1:0]   hi_mask;
  logic [N_REQ-1:0]   req_hi;
  logic [N_REQ-1:0]   req_pick;
  logic [N_REQ-1:0]   pick_oh;
  logic [REC_W-1:0]   rec_acc [N_REQ+1];
  logic [PTR_W-1:0]   sel_idx;
  logic [X_W-1:0]     sel_x;
  logic [Y_W-1:0]     sel_y;
  logic [SZ_W-1:0]    sel_w;
  logic [SZ_W-1:0]    sel_h;
  logic [COL_W-1:0]   sel_c;
  logic               col_last;
  logic               row_last;
  logic               emit;
  logic [X_W:0]       x_sum;
  logic [Y_W:0]       y_sum;

  // Round-robin pick: lowest set req at or above the pointer, else lowest set req overall.
  assign req_hi   = req & hi_mask;
  assign req_pick = (req_hi != '0) ? req_hi : req;
  assign pick_oh  = req_pick & (~req_pick + N_REQ'(1));

  // One-hot AND-OR mux of the winner's index and operands.
  assign rec_acc[0] = '0;
  for (genvar g = 0; g < N_REQ; g++) begin : g_req
    assign hi_mask[g]   = (PTR_W'(g) >= ptr_q);
    assign rec_acc[g+1] = rec_acc[g] | ({REC_W{pick_oh[g]}} &
                          {PTR_W'(g), x_in[g*X_W +: X_W], y_in[g*Y_W +: Y_W],
                           w_in[g*SZ_W +: SZ_W], h_in[g*SZ_W +: SZ_W],
                           colour_in[g*COL_W +: COL_W]});
  end
  assign {sel_idx, sel_x, sel_y, sel_w, sel_h, sel_c} = rec_acc[N_REQ];

  assign col_last = (col_q == bw_q - SZ_W'(1));
  assign row_last = (row_q == bh_q - SZ_W'(1));

  // Next state; the col/row counters always name the pixel being presented next cycle.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    bx_d         = bx_q;
    by_d         = by_q;
    bw_d         = bw_q;
    bh_d         = bh_q;
    bc_d         = bc_q;
    col_d        = col_q;
    row_d        = row_q;
    grant_d      = grant_q;
    done_d       = '0;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
    emit         = 1'b0;
    x_sum        = '0;
    y_sum        = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (req != '0) begin
          owner_d = sel_idx;
          bx_d    = sel_x;
          by_d    = sel_y;
          bw_d    = sel_w;
          bh_d    = sel_h;
          bc_d    = sel_c;
          col_d   = '0;
          row_d   = '0;
          grant_d = pick_oh;
          if ((sel_w == '0) || (sel_h == '0)) begin
            state_d = ST_DONE;
            done_d  = pick_oh;
          end else begin
            state_d = ST_DRAW;
            emit    = 1'b1;
          end
        end
      end
      ST_DRAW: begin
        if (col_last && row_last) begin
          state_d = ST_DONE;
          done_d  = grant_q;
        end else begin
          emit = 1'b1;
          if (col_last) begin
            col_d = '0;
            row_d = row_q + SZ_W'(1);
          end else begin
            col_d = col_q + SZ_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        grant_d = '0;
        ptr_d   = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase

    if (emit) begin
      x_sum        = (X_W+1)'(bx_d) + (X_W+1)'(col_d);
      y_sum        = (Y_W+1)'(by_d) + (Y_W+1)'(row_d);
      vga_x_d      = x_sum[X_W-1:0];
      vga_y_d      = y_sum[Y_W-1:0];
      vga_colour_d = bc_d;
      vga_plot_d   = (x_sum < (X_W+1)'(SCREEN_W)) && (y_sum < (Y_W+1)'(SCREEN_H));
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State, operand latches and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      bx_q         <= '0;
      by_q         <= '0;
      bw_q         <= '0;
      bh_q         <= '0;
      bc_q         <= '0;
      col_q        <= '0;
      row_q        <= '0;
      grant_q      <= '0;
      done_q       <= '0;
      busy_q       <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      bx_q         <= bx_d;
      by_q         <= by_d;
      bw_q         <= bw_d;
      bh_q         <= bh_d;
      bc_q         <= bc_d;
      col_q        <= col_d;
      row_q        <= row_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: directed scenarios plus randomized requesters,
// checked every cycle against a transaction-level model of the scheduler.
module tb_draw_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req = '0;
  logic [7:0]  op_x [2];
  logic [6:0]  op_y [2];
  logic [4:0]  op_w [2];
  logic [4:0]  op_h [2];
  logic [2:0]  op_c [2];
  logic [15:0] x_in;
  logic [13:0] y_in;
  logic [9:0]  w_in;
  logic [9:0]  h_in;
  logic [5:0]  colour_in;
  logic [1:0]  grant;
  logic [1:0]  done;
  logic        busy;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;

  assign x_in      = {op_x[1], op_x[0]};
  assign y_in      = {op_y[1], op_y[0]};
  assign w_in      = {op_w[1], op_w[0]};
  assign h_in      = {op_h[1], op_h[0]};
  assign colour_in = {op_c[1], op_c[0]};

  draw_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .x_in       (x_in),
    .y_in       (y_in),
    .w_in       (w_in),
    .h_in       (h_in),
    .colour_in  (colour_in),
    .grant      (grant),
    .done       (done),
    .busy       (busy),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  always #5 clk = ~clk;

  // Expected outputs for one cycle.
  typedef struct packed {
    logic [1:0] grant;
    logic [1:0] done;
    logic       busy;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } exp_t;

  exp_t       plan [$];
  exp_t       e = '0;
  logic [0:0] m_ptr = '0;
  logic [7:0] m_lx = '0;
  logic [6:0] m_ly = '0;
  logic [2:0] m_lc = '0;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_op(input logic [0:0] i, input int x, input int y, input int w,
                        input int h, input int c);
    op_x[i] = 8'(x);
    op_y[i] = 7'(y);
    op_w[i] = 5'(w);
    op_h[i] = 5'(h);
    op_c[i] = 3'(c);
  endtask

  task automatic model_reset();
    plan.delete();
    m_ptr = '0;
    m_lx  = '0;
    m_ly  = '0;
    m_lc  = '0;
  endtask

  // Whole rectangle as a cycle list: w*h pixels, the done cycle, one idle cycle.
  task automatic build(input logic [0:0] o);
    exp_t t;
    int   bx, by, w, h, px, py;
    bx = int'(op_x[o]);
    by = int'(op_y[o]);
    w  = int'(op_w[o]);
    h  = int'(op_h[o]);
    for (int r = 0; r < h; r++) begin
      for (int cc = 0; cc < w; cc++) begin
        px      = bx + cc;
        py      = by + r;
        t.grant = 2'b01 << o;
        t.done  = 2'b00;
        t.busy  = 1'b1;
        t.plot  = (px < 160) && (py < 120);
        t.x     = 8'(px);
        t.y     = 7'(py);
        t.c     = op_c[o];
        plan.push_back(t);
        m_lx = t.x;
        m_ly = t.y;
        m_lc = t.c;
      end
    end
    t = '{grant: 2'b01 << o, done: 2'b01 << o, busy: 1'b1, plot: 1'b0, x: m_lx, y: m_ly, c: m_lc};
    plan.push_back(t);
    t = '{grant: 2'b00, done: 2'b00, busy: 1'b0, plot: 1'b0, x: m_lx, y: m_ly, c: m_lc};
    plan.push_back(t);
    m_ptr = o + 1'b1;
  endtask

  // Advance the model across one rising edge using the inputs present at that edge.
  task automatic model_cycle();
    logic       found;
    logic [0:0] o;
    logic [0:0] i;
    if (plan.size() == 0) begin
      found = 1'b0;
      o     = '0;
      for (int k = 0; k < 2; k++) begin
        i = m_ptr + 1'(k);
        if (!found && req[i]) begin
          found = 1'b1;
          o     = i;
        end
      end
      if (found) build(o);
    end
    if (plan.size() == 0)
      e = '{grant: 2'b00, done: 2'b00, busy: 1'b0, plot: 1'b0, x: m_lx, y: m_ly, c: m_lc};
    else
      e = plan.pop_front();
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    check("grant",  32'(grant),      32'(e.grant));
    check("done",   32'(done),       32'(e.done));
    check("busy",   32'(busy),       32'(e.busy));
    check("plot",   32'(vga_plot),   32'(e.plot));
    check("vga_x",  32'(vga_x),      32'(e.x));
    check("vga_y",  32'(vga_y),      32'(e.y));
    check("colour", 32'(vga_colour), 32'(e.c));
  endtask

  task automatic check_zero();
    check("rst_grant",  32'(grant),      0);
    check("rst_done",   32'(done),       0);
    check("rst_busy",   32'(busy),       0);
    check("rst_plot",   32'(vga_plot),   0);
    check("rst_vga_x",  32'(vga_x),      0);
    check("rst_vga_y",  32'(vga_y),      0);
    check("rst_colour", 32'(vga_colour), 0);
  endtask

  // Leaves the bench at the falling edge of the first idle cycle after reset.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = '0;
    #1;
    check_zero();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  // Runs until a done pulse (bounded); k counts cycles from the request cycle.
  task automatic run_txn(input int max_cyc, output int done_cyc, output int plots,
                         output int owner);
    done_cyc = -1;
    plots    = 0;
    owner    = -1;
    for (int k = 1; k <= max_cyc && done_cyc < 0; k++) begin
      step();
      if (vga_plot) plots++;
      if (done != 2'b00) begin
        done_cyc = k;
        owner    = done[1] ? 1 : 0;
      end
    end
  endtask

  task automatic rand_op(input logic [0:0] i);
    op_x[i] = 8'(($urandom_range(3, 0) == 0) ? $urandom_range(255, 150) : $urandom_range(149, 0));
    op_y[i] = 7'(($urandom_range(3, 0) == 0) ? $urandom_range(127, 110) : $urandom_range(109, 0));
    op_w[i] = 5'($urandom_range(6, 0));
    op_h[i] = 5'($urandom_range(6, 0));
    op_c[i] = 3'($urandom_range(7, 0));
  endtask

  // Requester behaviour; also occasionally changes operands or drops req mid-draw.
  task automatic agent(input logic [0:0] i);
    if (e.done[i]) begin
      if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
      else rand_op(i);
    end else if (!req[i]) begin
      if ($urandom_range(3, 0) == 0) begin
        rand_op(i);
        req[i] = 1'b1;
      end
    end else if (e.grant[i] && $urandom_range(9, 0) == 0) begin
      if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
      else rand_op(i);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dc, pl, ow;
    for (int i = 0; i < 2; i++) set_op(1'(i), 0, 0, 0, 0, 0);

    // Single 2x2 rectangle.
    do_reset();
    set_op(1'b0, 10, 20, 2, 2, 3);
    req = 2'b01;
    run_txn(20, dc, pl, ow);
    check("t1_done_cycle", dc, 5);
    check("t1_plots", pl, 4);
    req = 2'b00;
    step();

    // Both requesting from reset, held: 0, then 1, then 0.
    do_reset();
    set_op(1'b0, 0, 0, 2, 1, 1);
    set_op(1'b1, 20, 20, 1, 2, 2);
    req = 2'b11;
    run_txn(20, dc, pl, ow);
    check("t2_first_owner", ow, 0);
    check("t2_first_done", dc, 3);
    run_txn(20, dc, pl, ow);
    check("t2_second_owner", ow, 1);
    run_txn(20, dc, pl, ow);
    check("t2_third_owner", ow, 0);
    req = 2'b00;
    step();
    step();

    // Right-edge clipping.
    do_reset();
    set_op(1'b0, 158, 10, 4, 1, 5);
    req = 2'b01;
    run_txn(20, dc, pl, ow);
    check("t3_done_cycle", dc, 5);
    check("t3_plots", pl, 2);
    req = 2'b00;
    step();

    // Zero-width rectangle.
    do_reset();
    set_op(1'b1, 5, 5, 0, 5, 7);
    req = 2'b10;
    run_txn(20, dc, pl, ow);
    check("t4_done_cycle", dc, 1);
    check("t4_plots", pl, 0);
    req = 2'b00;
    step();

    // Reset in the middle of a draw; pointer must return to requester 0.
    do_reset();
    set_op(1'b0, 30, 30, 1, 1, 2);
    req = 2'b01;
    run_txn(20, dc, pl, ow);
    check("t5_pre_done", dc, 2);
    req = 2'b00;
    step();
    set_op(1'b1, 40, 40, 4, 4, 6);
    req = 2'b10;
    step();
    step();
    step();
    reset = 1'b1;
    #1;
    check_zero();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    set_op(1'b0, 1, 2, 2, 2, 4);
    req = 2'b11;
    run_txn(20, dc, pl, ow);
    check("t5_owner_after_reset", ow, 0);
    check("t5_done_cycle", dc, 5);
    req = 2'b00;
    step();
    step();

    // Operands changed and req dropped mid-draw.
    do_reset();
    set_op(1'b0, 50, 60, 3, 2, 5);
    req = 2'b01;
    step();
    step();
    set_op(1'b0, 100, 100, 6, 6, 1);
    req = 2'b00;
    run_txn(20, dc, pl, ow);
    check("t6_done_cycle", dc, 5);
    check("t6_plots", pl, 4);
    step();

    // Randomized requesters.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      step();
      agent(1'b0);
      agent(1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
